// File: rtl/seg_pkg.sv
// seg_pkg: shared segment/anode encodings and digit geometry for the display bus
package seg_pkg;
  localparam int DIG_W = 3;
  localparam int NUM_POS = 4;
  localparam logic [6:0] SEG_D0 = 7'b0000001;
  localparam logic [6:0] SEG_D1 = 7'b1001111;
  localparam logic [6:0] SEG_D2 = 7'b0010010;
  localparam logic [6:0] SEG_D3 = 7'b0000110;
  localparam logic [6:0] SEG_D4 = 7'b1001100;
  localparam logic [6:0] SEG_D5 = 7'b0100100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN_P0 = 4'b1110;
  localparam logic [3:0] AN_P1 = 4'b1101;
  localparam logic [3:0] AN_P2 = 4'b1011;
  localparam logic [3:0] AN_P3 = 4'b0111;
endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: active-low a..g pattern to digit value plus legality flag
import seg_pkg::*;
module seg_pattern_decode (
  input  logic [6:0]       pat,
  output logic [DIG_W-1:0] val,
  output logic             legal
);
  // map the six legal glyphs; anything else decodes to 0 and is flagged illegal
  always_comb begin
    val = pat == SEG_D1 ? 3'd1 : pat == SEG_D2 ? 3'd2 : pat == SEG_D3 ? 3'd3 :
          pat == SEG_D4 ? 3'd4 : pat == SEG_D5 ? 3'd5 : 3'd0;
    legal = pat inside {SEG_D0, SEG_D1, SEG_D2, SEG_D3, SEG_D4, SEG_D5};
  end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: readback of the multiplexed 7-seg bus into digit registers; SEG_SCAN_SYNC_EN adds a 2-flop input synchronizer
import seg_pkg::*;
module seg_scan_decoder #(
  parameter int STABLE_CNT = 4,
  parameter int BLANK_LIMIT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [0:6]               seg_in,
  input  logic [3:0]               anode_in,
  input  logic                     clr_i,
  output logic [NUM_POS*DIG_W-1:0] dig_o,
  output logic [NUM_POS-1:0]       dig_valid_o,
  output logic                     upd_o,
  output logic [DIG_W-1:0]         lvl_o,
  output logic                     blank_o,
  output logic                     err_o
);
  localparam int BW = $clog2(BLANK_LIMIT + 1);
  localparam logic [3:0] S = 4'(STABLE_CNT);
  logic [10:0] src, key_q, prev_q;
  logic [3:0] run_cnt, run_nxt;
  logic [BW-1:0] blank_cnt, blank_nxt;
  logic [1:0] pos;
  logic [DIG_W-1:0] val;
  logic legal, valid, same, acc, good, chg, off, hit;
`ifdef SEG_SCAN_SYNC_EN
  logic [10:0] s1_q, s2_q;
  // two-flop synchronizer for a bus arriving from another clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= {anode_in, seg_in};
      s2_q <= s1_q;
    end
  end
  assign src = s2_q;
`else
  assign src = {anode_in, seg_in};
`endif
  seg_pattern_decode u_dec (.pat(key_q[6:0]), .val(val), .legal(legal));
  // stability filter and acceptance qualification on the registered key
  always_comb begin
    valid = key_q[10:7] != AN_OFF && key_q[6:0] != SEG_BLANK;
    same = key_q == prev_q;
    run_nxt = !valid ? 4'd0 : !same ? 4'd1 : run_cnt == S ? S : run_cnt + 4'd1;
    acc = valid && same && run_cnt == S - 4'd1;
    pos = key_q[10:7] == AN_P1 ? 2'd1 : key_q[10:7] == AN_P2 ? 2'd2 : key_q[10:7] == AN_P3 ? 2'd3 : 2'd0;
    good = legal && key_q[10:7] inside {AN_P0, AN_P1, AN_P2, AN_P3};
    chg = dig_o[pos*DIG_W +: DIG_W] != val || !dig_valid_o[pos];
    off = src[10:7] == AN_OFF;
    blank_nxt = !off ? '0 : blank_cnt == BW'(BLANK_LIMIT) ? blank_cnt : blank_cnt + 1'b1;
    hit = off && blank_cnt == BW'(BLANK_LIMIT - 1);
  end
  // key pipeline, run counter and blink detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '1;
      prev_q <= '1;
      run_cnt <= '0;
      blank_cnt <= '0;
      blank_o <= 1'b0;
    end else begin
      key_q <= src;
      prev_q <= key_q;
      run_cnt <= run_nxt;
      blank_cnt <= blank_nxt;
      blank_o <= acc ? 1'b0 : hit ? 1'b1 : blank_o;
    end
  end
  // digit registers, change strobe and sticky error; clear wins over acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_o <= '0;
      dig_valid_o <= '0;
      upd_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      upd_o <= !clr_i && acc && good && chg;
      if (clr_i) begin
        dig_o <= '0;
        dig_valid_o <= '0;
        err_o <= 1'b0;
      end else if (acc && good) begin
        dig_o[pos*DIG_W +: DIG_W] <= val;
        dig_valid_o[pos] <= 1'b1;
      end else if (acc) begin
        err_o <= 1'b1;
      end
    end
  end
  assign lvl_o = dig_o[2*DIG_W +: DIG_W];
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: table-driven scan vectors plus latency, reset, clear and blink sequences
module tb_seg_scan_decoder;
  import seg_pkg::*;
`ifdef SEG_SCAN_SYNC_EN
  localparam int XL = 2;
`else
  localparam int XL = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, clr_i = 1'b0;
  logic [0:6] seg_in = SEG_BLANK;
  logic [3:0] anode_in = AN_OFF;
  logic [11:0] dig_o;
  logic [3:0] dig_valid_o;
  logic upd_o, blank_o, err_o;
  logic [2:0] lvl_o;
  int checks = 0, errors = 0, pulses = 0;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          cyc;
    logic [11:0] dig;
    logic [3:0]  vld;
    logic        err;
    int          upd;
  } vec_t;
  vec_t tv[12];

  seg_scan_decoder dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .anode_in(anode_in), .clr_i(clr_i),
    .dig_o(dig_o), .dig_valid_o(dig_valid_o), .upd_o(upd_o), .lvl_o(lvl_o),
    .blank_o(blank_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (upd_o) pulses++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg);
    anode_in = an;
    seg_in = seg;
  endtask

  initial begin
    tv[0]  = '{AN_P2,   SEG_D3, 300, 12'h0C0, 4'b0100, 1'b0, 1};
    tv[1]  = '{AN_P1,   SEG_D0, 300, 12'h0C0, 4'b0110, 1'b0, 1};
    tv[2]  = '{AN_P0,   SEG_D0, 300, 12'h0C0, 4'b0111, 1'b0, 1};
    tv[3]  = '{AN_P2,   SEG_D3, 300, 12'h0C0, 4'b0111, 1'b0, 0};
    tv[4]  = '{AN_P1,   SEG_D0, 300, 12'h0C0, 4'b0111, 1'b0, 0};
    tv[5]  = '{AN_P0,   SEG_D0, 300, 12'h0C0, 4'b0111, 1'b0, 0};
    tv[6]  = '{AN_P3,   SEG_D5, 20,  12'hAC0, 4'b1111, 1'b0, 1};
    tv[7]  = '{AN_P0,   SEG_D4, 20,  12'hAC4, 4'b1111, 1'b0, 1};
    tv[8]  = '{AN_OFF,  SEG_D1, 20,  12'hAC4, 4'b1111, 1'b0, 0};
    tv[9]  = '{4'b1001, SEG_D2, 20,  12'hAC4, 4'b1111, 1'b1, 0};
    tv[10] = '{AN_P1,   SEG_D1, 20,  12'hACC, 4'b1111, 1'b1, 1};
    tv[11] = '{AN_P2,   SEG_D1, 20,  12'hA4C, 4'b1111, 1'b1, 1};

    step(3);
    rst_n = 1'b1;
    step(2);
    chk("reset dig", dig_o, 0);
    chk("reset valid", dig_valid_o, 0);
    chk("reset upd", upd_o, 0);
    chk("reset lvl", lvl_o, 0);
    chk("reset blank", blank_o, 0);
    chk("reset err", err_o, 0);

    for (int i = 0; i < 12; i++) begin
      drive(tv[i].an, tv[i].seg);
      pulses = 0;
      step(tv[i].cyc);
      chk($sformatf("vec%0d dig", i), dig_o, tv[i].dig);
      chk($sformatf("vec%0d valid", i), dig_valid_o, tv[i].vld);
      chk($sformatf("vec%0d err", i), err_o, tv[i].err);
      chk($sformatf("vec%0d lvl", i), lvl_o, tv[i].dig[8:6]);
      chk($sformatf("vec%0d upd pulses", i), pulses, tv[i].upd);
    end

    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      drive(AN_P1, SEG_D2);
      step(2);
      drive(AN_P1, SEG_BLANK);
      step(2);
    end
    chk("ghost upd pulses", pulses, 0);
    chk("ghost dig", dig_o, 12'hA4C);

    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    chk("clr dig", dig_o, 0);
    chk("clr valid", dig_valid_o, 0);
    chk("clr err", err_o, 0);

    drive(AN_P0, 7'b1111110);
    step(10);
    chk("illegal err", err_o, 1);
    chk("illegal valid", dig_valid_o, 0);
    drive(AN_P0, SEG_BLANK);
    step(20);
    chk("err sticky", err_o, 1);
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    chk("clr err2", err_o, 0);

    drive(AN_P3, SEG_D1);
    step(4 + XL);
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    chk("clr wins valid", dig_valid_o, 0);
    chk("clr wins upd", upd_o, 0);

    drive(AN_P2, SEG_D4);
    step(4 + XL);
    chk("lat early upd", upd_o, 0);
    chk("lat early valid", dig_valid_o, 0);
    step(1);
    chk("lat upd", upd_o, 1);
    chk("lat dig", dig_o, 12'h100);
    chk("lat valid", dig_valid_o, 4'b0100);
    step(1);
    chk("upd width", upd_o, 0);

    drive(AN_P0, SEG_D2);
    step(4 + XL);
    rst_n = 1'b0;
    #1;
    chk("midrst dig", dig_o, 0);
    chk("midrst valid", dig_valid_o, 0);
    chk("midrst lvl", lvl_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4 + XL);
    chk("post rst early valid", dig_valid_o, 0);
    step(1);
    chk("post rst valid", dig_valid_o, 4'b0001);
    chk("post rst dig", dig_o, 12'h002);

    drive(AN_P0, SEG_BLANK);
    step(2 + XL);
    drive(AN_OFF, SEG_BLANK);
    step(1023 + XL);
    chk("blank 1023", blank_o, 0);
    step(1);
    chk("blank 1024", blank_o, 1);
    step(50);
    chk("blank hold", blank_o, 1);
    drive(AN_P1, SEG_D5);
    step(4 + XL);
    chk("blank anode low", blank_o, 1);
    step(1);
    chk("blank cleared", blank_o, 0);
    chk("blink dig", dig_o, 12'h02A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
